cordic_polar_to_rect: RTL and testbench

//  Iterative CORDIC in rotation mode: converts one polar bin (magnitude, phase in degrees) to

---
 rtl/cordic_polar_to_rect_if.sv | 26 ++
 rtl/cordic_polar_to_rect.sv | 194 +++++++++++++++++++
 tb/tb_cordic_polar_to_rect.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/cordic_polar_to_rect_if.sv
// Bin transfer bus of the polar-to-rect CORDIC: polar bin in, packed {re,im} out.
// The master side is the bin source and result sink; the slave side is the converter.
interface cordic_polar_to_rect_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_mag;
  logic signed [15:0]      in_phase;
  logic [4:0]              in_freq;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*WIDTH-1:0]      out_data;
  logic [4:0]              out_freq;
  logic                    busy;

  modport master (
    output in_valid, in_mag, in_phase, in_freq, out_ready,
    input  in_ready, out_valid, out_data, out_freq, busy
  );

  modport slave (
    input  in_valid, in_mag, in_phase, in_freq, out_ready,
    output in_ready, out_valid, out_data, out_freq, busy
  );
endinterface

// File: rtl/cordic_polar_to_rect.sv
// Iterative rotation-mode CORDIC turning one polar bin (magnitude, whole-degree phase) into {re,im}.
// Build option CORDIC_GAIN_COMP_EN: scale the result by 39/64 to cancel the CORDIC gain K.
module cordic_polar_to_rect #(
  parameter int ITER  = 8,
  parameter int WIDTH = 16
) (
  input  logic                    clk_cal,
  input  logic                    rst,
  cordic_polar_to_rect_if.slave   bus
);

  localparam int DW = WIDTH + 2;
  localparam int ZW = 16;
  localparam int CW = 3;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITER - 1);
  localparam logic signed [DW-1:0] SAT_MAX = DW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [DW-1:0] SAT_MIN = -DW'(2 ** (WIDTH - 1));
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [DW+5:0] GAIN = (DW + 6)'(39);
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    SCALE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic signed [DW-1:0]    x_q, x_d;
  logic signed [DW-1:0]    y_q, y_d;
  logic signed [ZW-1:0]    z_q, z_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    neg_q, neg_d;
  logic [4:0]              freq_q, freq_d;
  logic [2*WIDTH-1:0]      out_data_q, out_data_d;

  logic signed [15:0]      ph_in;
  logic signed [15:0]      ph_clamp;
  logic signed [15:0]      ph_fold;
  logic                    neg_load;
  logic signed [DW-1:0]    dx, dy;
  logic signed [DW-1:0]    xs, ys;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [CW-1:0] idx);
    case (idx)
      3'd0:    return 16'sd2880;
      3'd1:    return 16'sd1700;
      3'd2:    return 16'sd898;
      3'd3:    return 16'sd456;
      3'd4:    return 16'sd229;
      3'd5:    return 16'sd115;
      3'd6:    return 16'sd57;
      default: return 16'sd29;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [DW-1:0] v);
    if (v > SAT_MAX) begin
      return WIDTH'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      return WIDTH'(SAT_MIN);
    end
    return WIDTH'(v);
  endfunction

  assign ph_in = bus.in_phase;

  // Phase is clamped to one turn, then folded into [-90,90] so the 8-entry table can reach it.
  always_comb begin
    ph_clamp = ph_in;
    if (ph_in > 16'sd180) begin
      ph_clamp = 16'sd180;
    end else if (ph_in < -16'sd180) begin
      ph_clamp = -16'sd180;
    end
    ph_fold  = ph_clamp;
    neg_load = 1'b0;
    if (ph_clamp > 16'sd90) begin
      ph_fold  = ph_clamp - 16'sd180;
      neg_load = 1'b1;
    end else if (ph_clamp < -16'sd90) begin
      ph_fold  = ph_clamp + 16'sd180;
      neg_load = 1'b1;
    end
  end

  assign dx = x_q >>> cnt_q;
  assign dy = y_q >>> cnt_q;
  assign xs = neg_q ? -x_q : x_q;
  assign ys = neg_q ? -y_q : y_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    freq_d     = freq_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d     = {2'b00, bus.in_mag};
          y_d     = '0;
          z_d     = ph_fold <<< 6;
          cnt_d   = '0;
          neg_d   = neg_load;
          freq_d  = bus.in_freq;
          state_d = ROTATE;
        end
      end

      ROTATE: begin
        if (!z_q[ZW-1]) begin
          x_d = x_q - dy;
          y_d = y_q + dx;
          z_d = z_q - atan_lut(cnt_q);
        end else begin
          x_d = x_q + dy;
          y_d = y_q - dx;
          z_d = z_q + atan_lut(cnt_q);
        end
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = SCALE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      // First SCALE cycle applies sign and gain, the second saturates into the output register,
      // keeping the multiplier and the clamp in separate cycles.
      SCALE: begin
        if (cnt_q == '0) begin
`ifdef CORDIC_GAIN_COMP_EN
          x_d = DW'(((DW + 6)'(xs) * GAIN) >>> 6);
          y_d = DW'(((DW + 6)'(ys) * GAIN) >>> 6);
`else
          x_d = xs;
          y_d = ys;
`endif
          neg_d = 1'b0;
          cnt_d = 3'd1;
        end else begin
          out_data_d = {sat(x_q), sat(y_q)};
          cnt_d      = '0;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_cal) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      freq_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      freq_q     <= freq_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_data  = out_data_q;
  assign bus.out_freq  = freq_q;

endmodule

// File: tb/tb_cordic_polar_to_rect.sv
// Directed bench for cordic_polar_to_rect: hand-worked CORDIC results, latency, handshake and reset.
// Expected values follow the CORDIC_GAIN_COMP_EN setting of the build.
module tb_cordic_polar_to_rect;

  logic clk_cal;
  logic rst;
  int   compared;
  int   mismatched;
  int   lat;

  cordic_polar_to_rect_if #(.WIDTH(16)) bus_if ();

  cordic_polar_to_rect #(.ITER(8), .WIDTH(16)) dut (
    .clk_cal (clk_cal),
    .rst     (rst),
    .bus     (bus_if.slave)
  );

  initial clk_cal = 1'b0;
  always #5 clk_cal = ~clk_cal;

  // Results worked by hand through the 8 micro-rotations (truncating shifts), then sign/gain/saturation.
`ifdef CORDIC_GAIN_COMP_EN
  localparam int RE_P0 = 1003,   IM_P0 = 6;
  localparam int RE_P90 = 6,     IM_P90 = 1003;
  localparam int RE_P180 = -1004, IM_P180 = -7;
  localparam int RE_M135 = -715, IM_M135 = -706;
  localparam int RE_H180 = -502, IM_H180 = -4;
  localparam int RE_FULL = 32767, IM_FULL = 231;
`else
  localparam int RE_P0 = 1647,   IM_P0 = 10;
  localparam int RE_P90 = 10,    IM_P90 = 1647;
  localparam int RE_P180 = -1647, IM_P180 = -10;
  localparam int RE_M135 = -1172, IM_M135 = -1157;
  localparam int RE_H180 = -823, IM_H180 = -6;
  localparam int RE_FULL = 32767, IM_FULL = 380;
`endif

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Present one bin and hold it until accepted; returns #1 after the accept edge with in_valid dropped.
  task automatic applyStimulus(input logic [15:0] mag, input logic signed [15:0] ph,
                               input logic [4:0] fr);
    int waited;
    bit stuck;
    @(negedge clk_cal);
    bus_if.in_mag   = mag;
    bus_if.in_phase = ph;
    bus_if.in_freq  = fr;
    bus_if.in_valid = 1'b1;
    waited = 0;
    while (bus_if.in_ready !== 1'b1 && waited < 40) begin
      @(negedge clk_cal);
      waited++;
    end
    stuck = (bus_if.in_ready !== 1'b1);
    compared++;
    assert (stuck === 1'b0) else begin
      mismatched++;
      $error("[TB] FAIL accept_timeout: observed in_ready low for %0d cycles, expected high", waited);
    end
    @(posedge clk_cal);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic waitResult(output int edges);
    bit seen;
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < 40) begin
      @(posedge clk_cal);
      #1;
      edges++;
      seen = (bus_if.out_valid === 1'b1);
    end
    compared++;
    assert (seen === 1'b1) else begin
      mismatched++;
      $error("[TB] FAIL result_timeout: observed no out_valid in %0d edges, expected out_valid", edges);
    end
  endtask

  task automatic checkOutput(input string tag, input int exp_re, input int exp_im,
                             input logic [4:0] exp_freq);
    check({tag, "_re"}, 32'($signed(bus_if.out_data[31:16])), 32'(exp_re));
    check({tag, "_im"}, 32'($signed(bus_if.out_data[15:0])), 32'(exp_im));
    check({tag, "_freq"}, {27'd0, bus_if.out_freq}, {27'd0, exp_freq});
  endtask

  // Accept the result and confirm the block returns to IDLE on that same edge.
  task automatic releaseOutput(input string tag);
    bus_if.out_ready = 1'b1;
    @(posedge clk_cal);
    #1;
    bus_if.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus_if.out_valid}, 32'd0);
    check({tag, "_ready_rise"}, {31'd0, bus_if.in_ready}, 32'd1);
  endtask

  initial begin
    bit ever_valid;
    compared         = 0;
    mismatched       = 0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_mag    = '0;
    bus_if.in_phase  = '0;
    bus_if.in_freq   = '0;
    bus_if.out_ready = 1'b0;
    rst              = 1'b1;
    repeat (3) @(posedge clk_cal);
    #1;
    rst = 1'b0;
    @(negedge clk_cal);
    check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_out_data", bus_if.out_data, 32'd0);
    check("rst_out_freq", {27'd0, bus_if.out_freq}, 32'd0);
    check("rst_busy", {31'd0, bus_if.busy}, 32'd0);

    // Phase 0, latency and frequency echo
    applyStimulus(16'd1000, 16'sd0, 5'd5);
    check("c1_busy", {31'd0, bus_if.busy}, 32'd1);
    check("c1_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    waitResult(lat);
    check("c1_latency", 32'(lat), 32'd10);
    checkOutput("c1", RE_P0, IM_P0, 5'd5);
    releaseOutput("c1");

    // Quadrant coverage including both folds
    applyStimulus(16'd1000, 16'sd90, 5'd7);
    waitResult(lat);
    checkOutput("c2_p90", RE_P90, IM_P90, 5'd7);
    releaseOutput("c2_p90");

    applyStimulus(16'd1000, 16'sd180, 5'd12);
    waitResult(lat);
    check("c2_latency", 32'(lat), 32'd10);
    checkOutput("c2_p180", RE_P180, IM_P180, 5'd12);
    releaseOutput("c2_p180");

    applyStimulus(16'd1000, -16'sd135, 5'd31);
    waitResult(lat);
    checkOutput("c2_m135", RE_M135, IM_M135, 5'd31);
    releaseOutput("c2_m135");

    // Phase clamping at both extremes
    applyStimulus(16'd500, 16'sd400, 5'd3);
    waitResult(lat);
    checkOutput("c3_p400", RE_H180, IM_H180, 5'd3);
    releaseOutput("c3_p400");

    applyStimulus(16'd500, 16'sh8000, 5'd17);
    waitResult(lat);
    checkOutput("c3_pmin", RE_H180, IM_H180, 5'd17);
    releaseOutput("c3_pmin");

    // Back-pressure: result held, new bin ignored while DONE
    applyStimulus(16'd1000, 16'sd0, 5'd9);
    waitResult(lat);
    bus_if.in_mag   = 16'd2000;
    bus_if.in_phase = 16'sd45;
    bus_if.in_freq  = 5'd21;
    bus_if.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_cal);
      #1;
      checkOutput($sformatf("c4_hold%0d", k), RE_P0, IM_P0, 5'd9);
      check($sformatf("c4_hold%0d_in_ready", k), {31'd0, bus_if.in_ready}, 32'd0);
      check($sformatf("c4_hold%0d_valid", k), {31'd0, bus_if.out_valid}, 32'd1);
    end
    bus_if.in_valid = 1'b0;
    releaseOutput("c4");
    check("c4_freq_kept", {27'd0, bus_if.out_freq}, 32'd9);

    // Full-scale magnitude saturates the real part
    applyStimulus(16'd32767, 16'sd0, 5'd1);
    waitResult(lat);
    checkOutput("c5_full", RE_FULL, IM_FULL, 5'd1);
    releaseOutput("c5_full");

    // Reset three cycles into ROTATE drops the bin
    applyStimulus(16'd1000, 16'sd90, 5'd22);
    repeat (3) @(posedge clk_cal);
    #1;
    rst = 1'b1;
    @(posedge clk_cal);
    #1;
    rst = 1'b0;
    check("c6_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check("c6_busy", {31'd0, bus_if.busy}, 32'd0);
    check("c6_out_data", bus_if.out_data, 32'd0);
    ever_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk_cal);
      #1;
      if (bus_if.out_valid === 1'b1) ever_valid = 1'b1;
    end
    check("c6_no_output", {31'd0, ever_valid}, 32'd0);
    applyStimulus(16'd1000, 16'sd0, 5'd5);
    waitResult(lat);
    check("c6_latency", 32'(lat), 32'd10);
    checkOutput("c6_after", RE_P0, IM_P0, 5'd5);
    releaseOutput("c6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
